id_stage_ctrl: RTL and testbench

- Decode-stage controller between fetch and execute.
- Accepts 32-bit instructions over a valid/ready handshake and classifies each into instr_type_t.
- Assembles the raw, unextended immediate field and presents it to the downstream sign_extend instance; execute consumes the sign_extend output.
- Two-entry skid buffer gives full throughput under backpressure; supports pipeline flush.

---
 rtl/id_stage_ctrl.sv | 155 +++++++++++++++
 tb/tb_id_stage_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: decode-stage controller between fetch and execute.
// Each instruction is decoded before it is stored, so the output fields come
// straight from registers. A two-entry skid buffer keeps full throughput
// under backpressure.
// Optional macro ID_STAGE_PERF_EN adds the stall and issue counter outputs.

package id_stage_pkg;
    typedef enum logic [2:0] {R, I, IJ, IL, S, B, U, J} instr_type_t;
endpackage

module id_stage_ctrl
    import id_stage_pkg::*;
#(
    parameter int unsigned wd_regs_p = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [31:0]          i_instr,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_flush,
    output logic [31:0]          o_instr,
    output instr_type_t          o_instr_type,
    output logic [wd_regs_p-1:0] o_immediate,
    output logic                 o_illegal,
    output logic                 o_valid,
`ifdef ID_STAGE_PERF_EN
    output logic [31:0]          o_stall_cnt,
    output logic [31:0]          o_issue_cnt,
`endif
    input  logic                 i_ready
);

    typedef struct packed {
        logic [31:0]          instr;
        instr_type_t          itype;
        logic [wd_regs_p-1:0] imm;
        logic                 ill;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    localparam entry_t ENTRY_RST = '{instr: '0, itype: R, imm: '0, ill: 1'b0};

    state_t state_q, state_d;
    logic   valid_q, ready_q;
    entry_t dec, out_q, out_d, skid_q, skid_d;
    logic   push, pop;

    assign push = i_valid & ready_q;
    assign pop  = valid_q & i_ready;

    // Classify the incoming instruction and assemble its raw immediate.
    always_comb begin
        dec       = ENTRY_RST;
        dec.instr = i_instr;
        case (i_instr[6:0])
            7'b0010011: begin dec.itype = I;  dec.imm[11:0] = i_instr[31:20]; end
            7'b1100111: begin dec.itype = IJ; dec.imm[11:0] = i_instr[31:20]; end
            7'b0000011: begin dec.itype = IL; dec.imm[11:0] = i_instr[31:20]; end
            7'b0100011: begin
                dec.itype     = S;
                dec.imm[11:0] = {i_instr[31:25], i_instr[11:7]};
            end
            7'b1100011: begin
                dec.itype     = B;
                dec.imm[12:0] = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            end
            7'b0110111,
            7'b0010111: begin dec.itype = U;  dec.imm[19:0] = i_instr[31:12]; end
            7'b1101111: begin
                dec.itype     = J;
                dec.imm[19:0] = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21]};
            end
            7'b0110011: dec.itype = R;
            default:    dec.ill   = 1'b1;
        endcase
    end

    // Next state and data movement; flush overrides every accept and pop.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) begin
                    state_d = ST_ONE;
                    out_d   = dec;
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_d = ST_TWO;
                        skid_d  = dec;
                    end else if (push && pop) begin
                        out_d = dec;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (pop) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State, handshake flags and held entries; ready/valid are registered
    // decodes of the next state so i_ready never reaches o_ready combinationally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != ST_EMPTY);
            ready_q <= (state_d != ST_TWO);
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = valid_q;
    assign o_instr      = out_q.instr;
    assign o_instr_type = out_q.itype;
    assign o_immediate  = out_q.imm;
    assign o_illegal    = out_q.ill;

`ifdef ID_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, issue_cnt_q;

    // Free-running wrap-around counters; flush does not touch them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (valid_q && !i_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (pop)                 issue_cnt_q <= issue_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl: directed test-plan steps followed by random
// traffic, checked against a queue model of the held instructions.
module tb_id_stage_ctrl;
    import id_stage_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_instr = '0;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ready, o_illegal, o_valid;
    logic [31:0] o_instr, o_immediate;
    instr_type_t o_instr_type;
`ifdef ID_STAGE_PERF_EN
    logic [31:0] o_stall_cnt, o_issue_cnt;
    int unsigned m_stall, m_issue;
`endif

    id_stage_ctrl #(.wd_regs_p(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_valid(i_valid),
        .o_ready(o_ready), .i_flush(i_flush), .o_instr(o_instr),
        .o_instr_type(o_instr_type), .o_immediate(o_immediate),
        .o_illegal(o_illegal), .o_valid(o_valid),
`ifdef ID_STAGE_PERF_EN
        .o_stall_cnt(o_stall_cnt), .o_issue_cnt(o_issue_cnt),
`endif
        .i_ready(i_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        instr_type_t itype;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Expected class and immediate, built with shifts and masks.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        e.instr = ins; e.itype = R; e.imm = 0; e.ill = 1'b0;
        case (ins & 32'h7F)
            32'h13: begin e.itype = I;  e.imm = ins >> 20; end
            32'h67: begin e.itype = IJ; e.imm = ins >> 20; end
            32'h03: begin e.itype = IL; e.imm = ins >> 20; end
            32'h23: begin e.itype = S;  e.imm = ((ins >> 25) << 5) | ((ins >> 7) & 31); end
            32'h63: begin
                e.itype = B;
                e.imm = (((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11)
                      | (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1);
            end
            32'h37, 32'h17: begin e.itype = U; e.imm = ins >> 12; end
            32'h6F: begin
                e.itype = J;
                e.imm = (((ins >> 31) & 1) << 19) | (((ins >> 12) & 255) << 11)
                      | (((ins >> 20) & 1) << 10) | ((ins >> 21) & 1023);
            end
            32'h33: e.itype = R;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("o_valid", {31'd0, o_valid}, {31'd0, q.size() > 0});
        chk("o_ready", {31'd0, o_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("o_instr", o_instr, q[0].instr);
            chk("o_instr_type", {29'd0, o_instr_type}, {29'd0, q[0].itype});
            chk("o_immediate", o_immediate, q[0].imm);
            chk("o_illegal", {31'd0, o_illegal}, {31'd0, q[0].ill});
        end
`ifdef ID_STAGE_PERF_EN
        chk("o_stall_cnt", o_stall_cnt, m_stall);
        chk("o_issue_cnt", o_issue_cnt, m_issue);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        bit push, pop;
        i_valid = v; i_instr = ins; i_ready = rdy; i_flush = fl;
        push = v && (q.size() < 2);
        pop  = (q.size() > 0) && rdy;
`ifdef ID_STAGE_PERF_EN
        if (q.size() > 0 && !rdy) m_stall++;
        if (pop) m_issue++;
`endif
        @(posedge i_clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(ref_decode(ins));
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        q.delete();
`ifdef ID_STAGE_PERF_EN
        m_stall = 0; m_issue = 0;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    localparam logic [31:0] INS_A = 32'h00A00093;
    localparam logic [31:0] INS_B = 32'h00112223;
    localparam logic [31:0] INS_C = 32'h123452B7;

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] r;
        ops = '{7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

        do_reset();
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_imm", o_immediate, 32'h0);
        chk("rst_illegal", {31'd0, o_illegal}, 32'h0);
        chk("rst_type", {29'd0, o_instr_type}, {29'd0, R});
        check_all();

        step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        chk("addi_type", {29'd0, o_instr_type}, {29'd0, I});
        chk("addi_imm", o_immediate, 32'h00000FFF);
        step(1'b1, 32'h00112223, 1'b1, 1'b0);
        chk("sw_imm", o_immediate, 32'h004);
        step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
        chk("beq_imm", o_immediate, 32'h1FFC);
        step(1'b1, 32'hFE000FE3, 1'b1, 1'b0);
        step(1'b1, 32'h123452B7, 1'b1, 1'b0);
        chk("lui_imm", o_immediate, 32'h12345);
        step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        chk("illegal", {31'd0, o_illegal}, 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: A and B taken, C held by fetch until space frees.
        step(1'b1, INS_A, 1'b0, 1'b0);
        step(1'b1, INS_B, 1'b0, 1'b0);
        chk("bp_ready_low", {31'd0, o_ready}, 32'h0);
        step(1'b1, INS_C, 1'b0, 1'b0);
        chk("bp_hold_A", o_instr, INS_A);
        step(1'b1, INS_C, 1'b1, 1'b0);
        chk("bp_out_B", o_instr, INS_B);
        step(1'b1, INS_C, 1'b1, 1'b0);
        chk("bp_out_C", o_instr, INS_C);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while full, with a same-cycle offer that must be dropped.
        step(1'b1, INS_A, 1'b0, 1'b0);
        step(1'b1, INS_B, 1'b0, 1'b0);
        step(1'b1, INS_C, 1'b1, 1'b1);
        chk("flush_valid", {31'd0, o_valid}, 32'h0);
        chk("flush_ready", {31'd0, o_ready}, 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while full.
        step(1'b1, INS_A, 1'b0, 1'b0);
        step(1'b1, INS_B, 1'b0, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, o_valid}, 32'h0);
        chk("arst_ready", {31'd0, o_ready}, 32'h1);
        do_reset();
        check_all();

`ifdef ID_STAGE_PERF_EN
        step(1'b1, INS_A, 1'b0, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, INS_B, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("perf_stall5", o_stall_cnt, 32'd5);
        chk("perf_issue2", o_issue_cnt, 32'd2);
`endif

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            r[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) r[6:0] = 7'($urandom());
            step($urandom_range(0, 9) < 7, r, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
